alu_srcb_fwd_stage: RTL

- Parametrised successor of the single-cycle ALU SrcB 2:1 selector, for the pipelined datapath.
- Resolves the rt operand from three sources: register file, EX/MEM forward, or MEM/WB forward.
- Selects between the resolved rt value and the sign-extended immediate.
- Registers the result into the ID/EX boundary with stall/flush control and saturating forwarding-event counters for performance debug.

---
 rtl/alu_srcb_fwd_stage_if.sv | 42 ++++
 rtl/alu_srcb_fwd_stage.sv | 114 +++++++++++
 2 files changed

// File: rtl/alu_srcb_fwd_stage_if.sv
// Decode-to-EX bundle for the SrcB forwarding stage: decode-side operands, forwarding
// taps from EX/MEM and MEM/WB, and the registered ID/EX outputs with their counters.
interface alu_srcb_fwd_stage_if #(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              stall;
   logic              flush;
   logic              alu_src_sel;
   logic [WIDTH-1:0]  rd2;
   logic [WIDTH-1:0]  imm;
   logic [REG_AW-1:0] rt_addr;
   logic              exmem_regwrite;
   logic [REG_AW-1:0] exmem_rd;
   logic [WIDTH-1:0]  exmem_result;
   logic              memwb_regwrite;
   logic [REG_AW-1:0] memwb_rd;
   logic [WIDTH-1:0]  memwb_result;
   logic              cnt_clear;
   logic [WIDTH-1:0]  srcb;
   logic [WIDTH-1:0]  store_data;
   logic              out_valid;
   logic [1:0]        fwd_sel;
   logic [CNT_W-1:0]  cnt_exmem;
   logic [CNT_W-1:0]  cnt_memwb;

   modport master (
      output in_valid, stall, flush, alu_src_sel, rd2, imm, rt_addr,
             exmem_regwrite, exmem_rd, exmem_result,
             memwb_regwrite, memwb_rd, memwb_result, cnt_clear,
      input  srcb, store_data, out_valid, fwd_sel, cnt_exmem, cnt_memwb
   );

   modport slave (
      input  in_valid, stall, flush, alu_src_sel, rd2, imm, rt_addr,
             exmem_regwrite, exmem_rd, exmem_result,
             memwb_regwrite, memwb_rd, memwb_result, cnt_clear,
      output srcb, store_data, out_valid, fwd_sel, cnt_exmem, cnt_memwb
   );
endinterface

// File: rtl/alu_srcb_fwd_stage.sv
// Pipelined ALU SrcB selector: resolves rt through EX/MEM and MEM/WB forwarding, picks
// rt or immediate, and registers the result into ID/EX with stall/flush and event counters.
module alu_srcb_fwd_stage #(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input logic                clk,
   input logic                reset,
   alu_srcb_fwd_stage_if.slave bus
);
   localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]  DATA_ZERO = {WIDTH{1'b0}};

   logic              hit_ex;
   logic              hit_wb;
   logic [1:0]        fwd_code;
   logic [WIDTH-1:0]  resolved_rt;
   logic              load;

   logic [WIDTH-1:0]  srcb_d, srcb_q;
   logic [WIDTH-1:0]  store_data_d, store_data_q;
   logic              out_valid_d, out_valid_q;
   logic [1:0]        fwd_sel_d, fwd_sel_q;
   logic [CNT_W-1:0]  cnt_exmem_d, cnt_exmem_q;
   logic [CNT_W-1:0]  cnt_memwb_d, cnt_memwb_q;

   always_comb begin
      hit_ex = bus.exmem_regwrite && (bus.exmem_rd == bus.rt_addr) && (bus.rt_addr != REG_ZERO);
      hit_wb = bus.memwb_regwrite && (bus.memwb_rd == bus.rt_addr) && (bus.rt_addr != REG_ZERO);
      // EX/MEM holds the younger result, so it takes priority over MEM/WB.
      if (hit_ex) begin
         fwd_code = 2'b01;
      end else if (hit_wb) begin
         fwd_code = 2'b10;
      end else begin
         fwd_code = 2'b00;
      end
      case (fwd_code)
         2'b01:   resolved_rt = bus.exmem_result;
         2'b10:   resolved_rt = bus.memwb_result;
         default: resolved_rt = bus.rd2;
      endcase
   end

   always_comb begin
      srcb_d       = srcb_q;
      store_data_d = store_data_q;
      out_valid_d  = out_valid_q;
      fwd_sel_d    = fwd_sel_q;
      load         = 1'b0;
      if (bus.flush) begin
         srcb_d       = DATA_ZERO;
         store_data_d = DATA_ZERO;
         out_valid_d  = 1'b0;
         fwd_sel_d    = 2'b00;
      end else if (bus.stall) begin
         load = 1'b0;
      end else begin
         load         = 1'b1;
         srcb_d       = bus.alu_src_sel ? bus.imm : resolved_rt;
         store_data_d = resolved_rt;
         out_valid_d  = bus.in_valid;
         fwd_sel_d    = bus.in_valid ? fwd_code : 2'b00;
      end
   end

   always_comb begin
      cnt_exmem_d = cnt_exmem_q;
      cnt_memwb_d = cnt_memwb_q;
      if (bus.cnt_clear) begin
         cnt_exmem_d = {CNT_W{1'b0}};
         cnt_memwb_d = {CNT_W{1'b0}};
      end else if (load && bus.in_valid) begin
         // Only one counter moves per instruction; each sticks at all-ones.
         if (hit_ex) begin
            cnt_exmem_d = (cnt_exmem_q == CNT_MAX) ? cnt_exmem_q : (cnt_exmem_q + CNT_ONE);
         end else if (hit_wb) begin
            cnt_memwb_d = (cnt_memwb_q == CNT_MAX) ? cnt_memwb_q : (cnt_memwb_q + CNT_ONE);
         end else begin
            cnt_exmem_d = cnt_exmem_q;
         end
      end else begin
         cnt_exmem_d = cnt_exmem_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         srcb_q       <= DATA_ZERO;
         store_data_q <= DATA_ZERO;
         out_valid_q  <= 1'b0;
         fwd_sel_q    <= 2'b00;
         cnt_exmem_q  <= {CNT_W{1'b0}};
         cnt_memwb_q  <= {CNT_W{1'b0}};
      end else begin
         srcb_q       <= srcb_d;
         store_data_q <= store_data_d;
         out_valid_q  <= out_valid_d;
         fwd_sel_q    <= fwd_sel_d;
         cnt_exmem_q  <= cnt_exmem_d;
         cnt_memwb_q  <= cnt_memwb_d;
      end
   end

   assign bus.srcb       = srcb_q;
   assign bus.store_data = store_data_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.fwd_sel    = fwd_sel_q;
   assign bus.cnt_exmem  = cnt_exmem_q;
   assign bus.cnt_memwb  = cnt_memwb_q;
endmodule
